// File: rtl/keyword_lexer_if.sv
// Character-in / token-out handshake bundle for the keyword lexer.
// The slave modport is the lexer; the master side drives characters and consumes tokens.
interface keyword_lexer_if #(
  parameter int LENW = 4
);
  logic            in_valid;
  logic [7:0]      in_char;
  logic            in_last;
  logic            in_ready;
  logic            tok_valid;
  logic [1:0]      tok_type;
  logic [LENW-1:0] tok_len;
  logic            tok_ready;
  logic            overflow;

  modport master (
    output in_valid, in_char, in_last, tok_ready,
    input  in_ready, tok_valid, tok_type, tok_len, overflow
  );

  modport slave (
    input  in_valid, in_char, in_last, tok_ready,
    output in_ready, tok_valid, tok_type, tok_len, overflow
  );
endinterface

// File: rtl/keyword_lexer.sv
// Splits a character stream into space-delimited words, classifies each as BEGIN/END/OTHER
// case-insensitively and queues the resulting tokens in a small FIFO.
module keyword_lexer #(
  parameter int DEPTH = 4,
  parameter int LENW  = 4
) (
  input  logic           clk,
  input  logic           reset,
  keyword_lexer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LENW-1:0] LMAX = '1;
  localparam logic [1:0] T_BEGIN = 2'b01;
  localparam logic [1:0] T_END   = 2'b10;
  localparam logic [1:0] T_OTHER = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
  } state_t;

  typedef struct packed {
    logic [1:0]      ty;
    logic [LENW-1:0] len;
  } tok_t;

  state_t          st, st_nxt;
  logic [LENW-1:0] len_q, len_inc;
  logic [7:0]      ch;
  logic            is_delim, acc, push, pop, ovf_q;
  tok_t            push_tok;
  tok_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt;

  function automatic logic [1:0] tok_code(input state_t s);
    case (s)
      S_BEGIN: tok_code = T_BEGIN;
      S_END:   tok_code = T_END;
      default: tok_code = T_OTHER;
    endcase
  endfunction

  // Conservative back-pressure: any character stalls when the FIFO is full.
  assign bus.in_ready = !reset && (cnt < (AW+1)'(DEPTH));
  assign acc      = bus.in_valid && bus.in_ready;
  assign is_delim = (bus.in_char == 8'h20);
  assign ch       = (bus.in_char >= 8'h41 && bus.in_char <= 8'h5A) ? bus.in_char + 8'h20
                                                                  : bus.in_char;
  assign len_inc  = (len_q == LMAX) ? LMAX : len_q + 1'b1;

  always_comb begin
    st_nxt = S_OTHER;
    case (st)
      S_IDLE:  st_nxt = (ch == 8'h62) ? S_B : (ch == 8'h65) ? S_E : S_OTHER;
      S_B:     if (ch == 8'h65) st_nxt = S_BE;
      S_BE:    if (ch == 8'h67) st_nxt = S_BEG;
      S_BEG:   if (ch == 8'h69) st_nxt = S_BEGI;
      S_BEGI:  if (ch == 8'h6E) st_nxt = S_BEGIN;
      S_E:     if (ch == 8'h6E) st_nxt = S_EN;
      S_EN:    if (ch == 8'h64) st_nxt = S_END;
      default: st_nxt = S_OTHER;
    endcase
  end

  // A word ends on a delimiter (classified as-is) or on a last character (classified with it).
  always_comb begin
    push     = 1'b0;
    push_tok = '0;
    if (acc) begin
      if (is_delim) begin
        push     = (st != S_IDLE);
        push_tok = '{ty: tok_code(st), len: len_q};
      end else if (bus.in_last) begin
        push     = 1'b1;
        push_tok = '{ty: tok_code(st_nxt), len: len_inc};
      end
    end
  end

  assign pop = (cnt != '0) && bus.tok_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= S_IDLE;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (acc) begin
      if (is_delim || bus.in_last) begin
        st    <= S_IDLE;
        len_q <= '0;
      end else begin
        st    <= st_nxt;
        len_q <= len_inc;
      end
      if (!is_delim && len_q == LMAX - 1'b1) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_tok;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign bus.tok_valid = (cnt != '0);
  assign bus.tok_type  = mem[rd_ptr].ty;
  assign bus.tok_len   = mem[rd_ptr].len;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_keyword_lexer.sv
// Directed bench for keyword_lexer: a word-level reference model checked every cycle,
// plus literal token expectations for each scenario.
module tb_keyword_lexer;
  localparam int DEPTH = 4;
  localparam int LENW  = 4;
  localparam logic [63:0] W_BEGIN = 64'h0000_0062_6567_696E;
  localparam logic [63:0] W_END   = 64'h0000_0000_0065_6E64;

  typedef struct {
    int ty;
    int len;
  } mtok_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  keyword_lexer_if #(.LENW(LENW)) bus();

  keyword_lexer #(.DEPTH(DEPTH), .LENW(LENW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_fail = 0;
  bit    chk_on = 1'b0;
  mtok_t mq[$];
  mtok_t log_q[$];
  int    wlen = 0;
  logic [63:0] wv = '0;
  bit    m_ovf = 1'b0;

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic mtok_t word_tok(input int n, input logic [63:0] w);
    mtok_t t;
    if (n == 5 && w == W_BEGIN)    t.ty = 1;
    else if (n == 3 && w == W_END) t.ty = 2;
    else                           t.ty = 3;
    t.len = (n > 15) ? 15 : n;
    return t;
  endfunction

  // Reference model: whole-word view of the stream plus a token queue.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      wlen = 0; wv = '0; m_ovf = 1'b0;
    end else begin
      bit pop, acc, do_push;
      logic [7:0] c;
      mtok_t t;
      pop = (mq.size() > 0) && bus.tok_ready;
      acc = bus.in_valid && (mq.size() < DEPTH);
      do_push = 1'b0;
      if (acc) begin
        if (bus.in_char == 8'h20) begin
          if (wlen > 0) begin do_push = 1'b1; t = word_tok(wlen, wv); end
          wlen = 0; wv = '0;
        end else begin
          c = bus.in_char;
          if (c >= "A" && c <= "Z") c = c + 8'd32;
          wv = {wv[55:0], c};
          wlen++;
          if (wlen >= 15) m_ovf = 1'b1;
          if (bus.in_last) begin
            do_push = 1'b1; t = word_tok(wlen, wv);
            wlen = 0; wv = '0;
          end
        end
      end
      if (pop) begin log_q.push_back(mq[0]); void'(mq.pop_front()); end
      if (do_push) mq.push_back(t);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("in_ready", int'(bus.in_ready), int'(!reset && mq.size() < DEPTH));
      check("tok_valid", int'(bus.tok_valid), int'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("tok_type", int'(bus.tok_type), mq[0].ty);
        check("tok_len", int'(bus.tok_len), mq[0].len);
      end
      check("overflow", int'(bus.overflow), int'(m_ovf));
    end
  end

  task automatic send(input logic [7:0] c, input bit last);
    bit acc;
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_char = c; bus.in_last = last;
    forever begin
      #1 acc = bus.in_ready;
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 200) begin check("send_timeout", 0, 1); break; end
      @(negedge clk);
    end
    #1 bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
  endtask

  task automatic log_tok(input string nm, input int idx, input int ty, input int len);
    if (log_q.size() > idx) begin
      check({nm, "_type"}, log_q[idx].ty, ty);
      check({nm, "_len"}, log_q[idx].len, len);
    end else begin
      check({nm, "_present"}, log_q.size(), idx + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_char = 8'h00; bus.in_last = 1'b0; bus.tok_ready = 1'b0;
    idle(3);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_tok_valid", int'(bus.tok_valid), 0);
    check("rst_tok_type", int'(bus.tok_type), 0);
    check("rst_tok_len", int'(bus.tok_len), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    @(negedge clk); #2 reset = 1'b0;
    chk_on = 1'b1;

    // 1: mixed case keywords and redundant spaces
    bus.tok_ready = 1'b1;
    log_q.delete();
    send_str(" BEgIn EndC  enD ", 1'b0);
    idle(4);
    check("t1_count", log_q.size(), 3);
    log_tok("t1_0", 0, 1, 5);
    log_tok("t1_1", 1, 3, 4);
    log_tok("t1_2", 2, 2, 3);

    // 2: word closed by in_last, classification includes the last char
    log_q.delete();
    bus.tok_ready = 1'b0;
    send_str("endBEgIn", 1'b1);
    @(negedge clk);
    check("t2_valid", int'(bus.tok_valid), 1);
    check("t2_type", int'(bus.tok_type), 3);
    check("t2_len", int'(bus.tok_len), 8);
    bus.tok_ready = 1'b1;
    idle(3);

    // 3: fill the FIFO, stall, then drain in order
    log_q.delete();
    bus.tok_ready = 1'b0;
    send_str("a bb ccc dddd ", 1'b0);
    fork
      send_str("e ", 1'b0);
      begin
        idle(4);
        #1;
        check("t3_stalled", int'(bus.in_ready), 0);
        check("t3_full_len", int'(bus.tok_len), 1);
        bus.tok_ready = 1'b1;
      end
    join
    idle(8);
    check("t3_count", log_q.size(), 5);
    log_tok("t3_a", 0, 3, 1);
    log_tok("t3_b", 1, 3, 2);
    log_tok("t3_c", 2, 3, 3);
    log_tok("t3_d", 3, 3, 4);
    log_tok("t3_e", 4, 3, 1);

    // 4: push and pop on the same edge at count 2
    log_q.delete();
    bus.tok_ready = 1'b0;
    send_str("a bb ccc", 1'b0);
    @(negedge clk);
    bus.tok_ready = 1'b1; bus.in_valid = 1'b1; bus.in_char = 8'h20; bus.in_last = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.tok_ready = 1'b0;
    @(negedge clk);
    check("t4_head_len", int'(bus.tok_len), 2);
    check("t4_valid", int'(bus.tok_valid), 1);
    bus.tok_ready = 1'b1;
    idle(5);
    check("t4_count", log_q.size(), 3);
    log_tok("t4_0", 0, 3, 1);
    log_tok("t4_1", 1, 3, 2);
    log_tok("t4_2", 2, 3, 3);

    // 5: length saturation and sticky overflow
    log_q.delete();
    check("t5_ovf_before", int'(bus.overflow), 0);
    for (int i = 0; i < 20; i++) send("x", 1'b0);
    send(" ", 1'b0);
    idle(3);
    log_tok("t5_tok", 0, 3, 15);
    send_str("be ", 1'b0);
    idle(3);
    check("t5_ovf_held", int'(bus.overflow), 1);

    // 6: asynchronous reset mid-word with tokens queued
    log_q.delete();
    bus.tok_ready = 1'b0;
    send_str("x y beg", 1'b0);
    @(negedge clk);
    check("t6_queued", int'(bus.tok_valid), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t6_async_valid", int'(bus.tok_valid), 0);
    check("t6_async_ovf", int'(bus.overflow), 0);
    check("t6_async_ready", int'(bus.in_ready), 0);
    idle(2);
    #2 reset = 1'b0;
    log_q.delete();
    bus.tok_ready = 1'b1;
    send_str("in ", 1'b0);
    idle(3);
    check("t6_count", log_q.size(), 1);
    log_tok("t6_tok", 0, 3, 2);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
